rca_grid_lsq: RTL
=================

// Module: rca_grid_lsq
// PURPOSE
// - LSQ end of rca_lsq_grid_interface and master end of rca_lsu_interface.
// - Collects per-row load/store requests from the RCA grid and serialises them in
//   row order into the shared Taiga LSU. Returns load data to the requesting row.
// - Sits between the RCA grid and load_store_unit. Holds the LSU lock while RCA
//   memory traffic is pending.
// PARAMETERS
// - FIFO_DEPTH  8  request FIFO entries; power of 2, >= GRID_NUM_ROWS (rca_config)
// PORTS
// - clk      input   1         core clock
// - rst      input   1         asynchronous, active-low reset
// - grid     modport rca_lsq_grid_interface.lsq   requests in; fifo_full, load_complete, load_data out
// - lsu      modport rca_lsu_interface.lsq        requests to LSU; lsu_ready, load_complete, load_data in
// - rca_id   input   id_t      instruction id of the active RCA op, forwarded on lsu.id
// BEHAVIOUR
// - Reset values: all outputs 0.
//   - grid.fifo_full=0, grid.load_complete[*]=0, grid.load_data=0.
//   - lsu.new_request=0, lsu.rca_lsu_lock=0, lsu.rs1/rs2/fn3/load/store/id=0.
//   - Internal state: FIFO empty, hold regs invalid, FSM=IDLE.
// - Capture:
//   - Each cycle, every row r with grid.new_request[r]=1 is latched into hold[r]
//     as {row r, addr, data, fn3, load, store}.
//   - Any subset of rows may request in the same cycle.
// - Drain: one valid hold entry per cycle, lowest row index first, is pushed into
//   the FIFO. Same-cycle requests therefore reach the LSU in ascending row order.
// - grid.fifo_full is combinational from registered state:
//   - fifo_full = (fifo_count + held_count) > (FIFO_DEPTH - GRID_NUM_ROWS).
//   - Guarantees room for all rows requesting at once.
//   - grid.new_request while fifo_full=1 is a protocol violation (assertion); the
//     request is dropped.
// - Latency:
//   - Row request at cycle 0 -> hold at 1 -> FIFO head at 2.
//   - Earliest lsu.new_request is at cycle 2.
// - FSM IDLE:
//   - If FIFO valid and lsu.lsu_ready: pulse lsu.new_request for 1 cycle.
//     - rs1=addr (offset already applied), rs2=data, fn3, load, store, id=rca_id.
//     - Pop the FIFO.
//   - Next state: store -> IDLE; load -> WAIT_LOAD (row index saved).
// - FSM WAIT_LOAD:
//   - No further issue.
//   - On lsu.load_complete: register lsu.load_data into grid.load_data, pulse
//     grid.load_complete[saved_row] the next cycle, -> IDLE.
//   - grid.load_data holds until the next load completes.
// - Only one load is outstanding; stores are fire-and-forget. In-order, no reordering
//   or store-to-load forwarding.
// - lsu.rca_lsu_lock=1 while any hold entry is valid, the FIFO is non-empty, or
//   FSM=WAIT_LOAD. Deasserts the cycle after the last store issues or the last
//   load completes.
// - Boundaries:
//   - lsu_ready=0: FIFO head stays stable and no pulse is issued.
//   - FIFO full plus a hold entry: drain stalls; the hold entry is kept.
//   - Pointer wrap: modulo FIFO_DEPTH, count is clog2(FIFO_DEPTH)+1 bits.
//   - lsu.load_complete in IDLE: ignored.
//   - Reset mid-operation: all queued and in-flight requests are discarded; a late
//     load_complete after reset is ignored.
// STRUCTURE
// - rca_config gets lsq_entry_t {row idx $clog2(GRID_NUM_ROWS), addr, data, fn3,
//   load, store} and the FSM enum lsq_state_t {IDLE, WAIT_LOAD}.
// - One sub-module, rca_lsq_fifo: a circular buffer of lsq_entry_t with async
//   active-low reset, push/pop/count/valid.
// TESTING
// - Single load, row 2:
//   - Stimulus: addr=0x100; LSU returns 0xDEADBEEF 3 cycles after issue.
//   - Response: lsu.new_request at cycle 2, rs1=0x100, load=1.
//   - Response: grid.load_complete[2]=1 exactly one cycle after lsu.load_complete,
//     load_data=0xDEADBEEF.
// - Rows 0, 1 and 3 store in the same cycle:
//   - Response: three lsu.new_request pulses, in row order 0, 1, 3, on consecutive
//     lsu_ready cycles.
//   - Response: no grid.load_complete.
// - Load (row 0) then store (row 1):
//   - Response: the store is not issued until load_complete is seen; lock is high
//     throughout.
// - Fill to threshold, FIFO_DEPTH=8, 4 rows, lsu_ready=0:
//   - Response: fifo_full rises when count+held=5.
//   - Response: after lsu_ready=1, all entries drain; fifo_full falls when the
//     count reaches 4.
// - Assert rst low while in WAIT_LOAD, then release:
//   - Response: all outputs are 0, and a subsequent lsu.load_complete produces no
//     grid.load_complete.
// - Stall lsu_ready=0 for 10 cycles with the head valid:
//   - Response: lsu.rs1/rs2 stay stable, no new_request pulse, and
//     rca_lsu_lock stays 1.

Source files
------------

// File: rtl/rca_grid_lsq_pkg.sv
// rtl/rca_grid_lsq_pkg.sv - shared types and sizes for the RCA grid load/store queue
package rca_grid_lsq_pkg;

    localparam int GRID_NUM_ROWS = 4;
    localparam int XLEN          = 32;
    localparam int ID_W          = 3;
    localparam int ROW_W         = $clog2(GRID_NUM_ROWS);

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [2:0]       fn3;
        logic             load;
        logic             store;
    } lsq_entry_t;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } lsq_state_t;

    function automatic logic [ROW_W:0] popcount_rows(input logic [GRID_NUM_ROWS-1:0] v);
        logic [ROW_W:0] c;
        c = '0;
        for (int i = 0; i < GRID_NUM_ROWS; i++) begin
            c = c + (ROW_W+1)'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rca_grid_lsq_if.sv
// rtl/rca_grid_lsq_if.sv - grid-side and LSU-side request interfaces of the RCA load/store queue
interface rca_lsq_grid_interface;
    import rca_grid_lsq_pkg::*;

    logic [GRID_NUM_ROWS-1:0]           new_request;
    logic [GRID_NUM_ROWS-1:0][XLEN-1:0] addr;
    logic [GRID_NUM_ROWS-1:0][XLEN-1:0] data;
    logic [GRID_NUM_ROWS-1:0][2:0]      fn3;
    logic [GRID_NUM_ROWS-1:0]           load;
    logic [GRID_NUM_ROWS-1:0]           store;
    logic                               fifo_full;
    logic [GRID_NUM_ROWS-1:0]           load_complete;
    logic [XLEN-1:0]                    load_data;

    modport lsq  (input  new_request, addr, data, fn3, load, store,
                  output fifo_full, load_complete, load_data);
    modport grid (output new_request, addr, data, fn3, load, store,
                  input  fifo_full, load_complete, load_data);
endinterface

interface rca_lsu_interface;
    import rca_grid_lsq_pkg::*;

    logic            new_request;
    logic            rca_lsu_lock;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
    id_t             id;
    logic            lsu_ready;
    logic            load_complete;
    logic [XLEN-1:0] load_data;

    modport lsq (output new_request, rca_lsu_lock, rs1, rs2, fn3, load, store, id,
                 input  lsu_ready, load_complete, load_data);
    modport lsu (input  new_request, rca_lsu_lock, rs1, rs2, fn3, load, store, id,
                 output lsu_ready, load_complete, load_data);
endinterface

// File: rtl/rca_grid_lsq_fifo.sv
// rtl/rca_grid_lsq_fifo.sv - circular request buffer of lsq_entry_t with first-word fall-through head
module rca_lsq_fifo
    import rca_grid_lsq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  lsq_entry_t                 i_entry,
    input  logic                       i_pop,
    output lsq_entry_t                 o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lsq_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/rca_grid_lsq.sv
// rtl/rca_grid_lsq.sv - serialises per-row RCA grid memory requests into the shared LSU in row order
module rca_grid_lsq
    import rca_grid_lsq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rca_lsq_grid_interface.lsq    grid,
    rca_lsu_interface.lsq         lsu,
    input  id_t                   i_rca_id
);
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int FULL_THRESH = FIFO_DEPTH - GRID_NUM_ROWS;

    lsq_entry_t               r_hold [GRID_NUM_ROWS];
    logic [GRID_NUM_ROWS-1:0] r_hold_valid;
    lsq_state_t               r_state;
    logic [ROW_W-1:0]         r_load_row;
    logic [GRID_NUM_ROWS-1:0] r_load_complete;
    logic [XLEN-1:0]          r_load_data;

    lsq_entry_t               w_fifo_head;
    logic                     w_fifo_valid;
    logic [CNT_W-1:0]         w_fifo_count;
    logic [CNT_W:0]           w_occupancy;
    logic                     w_fifo_full;
    logic [GRID_NUM_ROWS-1:0] w_capture;
    logic                     w_drain_any;
    logic [ROW_W-1:0]         w_drain_idx;
    logic                     w_push;
    logic                     w_present;
    logic                     w_issue;

    // Descending scan so the lowest valid row is the one that wins.
    always_comb begin
        w_drain_any = 1'b0;
        w_drain_idx = '0;
        for (int r = GRID_NUM_ROWS - 1; r >= 0; r--) begin
            if (r_hold_valid[r]) begin
                w_drain_any = 1'b1;
                w_drain_idx = ROW_W'(r);
            end
        end
    end

    // Threshold leaves room for every row to request in the same cycle.
    assign w_occupancy = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(popcount_rows(r_hold_valid));
    assign w_fifo_full = w_occupancy > (CNT_W+1)'(FULL_THRESH);
    assign w_capture   = grid.new_request & {GRID_NUM_ROWS{~w_fifo_full}};
    assign w_push      = w_drain_any && (w_fifo_count < CNT_W'(FIFO_DEPTH));
    assign w_present   = (r_state == IDLE) && w_fifo_valid;
    assign w_issue     = w_present && lsu.lsu_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_valid <= '0;
            for (int r = 0; r < GRID_NUM_ROWS; r++) r_hold[r] <= '0;
        end else begin
            for (int r = 0; r < GRID_NUM_ROWS; r++) begin
                if (w_capture[r]) begin
                    r_hold_valid[r] <= 1'b1;
                    r_hold[r]       <= '{row: ROW_W'(r), addr: grid.addr[r], data: grid.data[r],
                                         fn3: grid.fn3[r], load: grid.load[r], store: grid.store[r]};
                end else if (w_push && (w_drain_idx == ROW_W'(r))) begin
                    r_hold_valid[r] <= 1'b0;
                end
            end
        end
    end

    rca_lsq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_entry (r_hold[w_drain_idx]),
        .i_pop   (w_issue),
        .o_head  (w_fifo_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_load_row      <= '0;
            r_load_complete <= '0;
            r_load_data     <= '0;
        end else begin
            r_load_complete <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_issue && w_fifo_head.load) begin
                        r_state    <= WAIT_LOAD;
                        r_load_row <= w_fifo_head.row;
                    end
                end
                WAIT_LOAD: begin
                    if (lsu.load_complete) begin
                        r_load_data                 <= lsu.load_data;
                        r_load_complete[r_load_row] <= 1'b1;
                        r_state                     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!((|grid.new_request) && w_fifo_full));
        end
    end

    assign grid.fifo_full     = w_fifo_full;
    assign grid.load_complete = r_load_complete;
    assign grid.load_data     = r_load_data;

    assign lsu.new_request  = w_issue;
    assign lsu.rca_lsu_lock = (|r_hold_valid) || w_fifo_valid || (r_state == WAIT_LOAD);
    assign lsu.rs1          = w_present ? w_fifo_head.addr  : '0;
    assign lsu.rs2          = w_present ? w_fifo_head.data  : '0;
    assign lsu.fn3          = w_present ? w_fifo_head.fn3   : '0;
    assign lsu.load         = w_present && w_fifo_head.load;
    assign lsu.store        = w_present && w_fifo_head.store;
    assign lsu.id           = w_present ? i_rca_id : '0;

endmodule
